score_bcd_scanner: RTL and testbench
====================================

// Module: score_bcd_scanner
// PURPOSE
//  Parametrised score keeper for the snake game: counts good collisions directly in BCD,
//  tracks the high score and runs a PLAY/OVER game state machine.
//  Time-multiplexes the displayed value onto DIGITS seven-segment positions, with
//  leading-zero blanking and a blinking high-score display on game over.
//  Sits between the collision logic / pushbuttons and the ssdec decoders in top.
// PARAMETERS
//  DIGITS     3    number of BCD digits kept and scanned (10**DIGITS > MAX_SCORE required)
//  MAX_SCORE  140  score at which the game ends automatically (>=1)
//  BLINK_DIV  50   clk cycles per blink half-period in OVER (>=1)
//  SW         $clog2(MAX_SCORE+1)  derived binary score width (localparam)
// PORTS
//  clk          in   1         system clock (hz100 in top)
//  rst          in   1         asynchronous active-high reset
//  good_i       in   1         good-collision level, synchronous to clk
//  bad_i        in   1         bad-collision level, synchronous to clk
//  clear_hi_i   in   1         level; clears high score
//  score_o      out  SW        current binary score
//  high_o       out  SW        binary high score
//  bcd_o        out  4*DIGITS  displayed value in BCD (digit 0 = ones in [3:0])
//  game_over_o  out  1         1 while in OVER
//  digit_sel_o  out  DIGITS    one-hot scan position being driven
//  digit_o      out  4         BCD digit for the selected position
//  digit_en_o   out  1         1 = light selected position, 0 = blank it
// BEHAVIOUR
//  Reset: every register cleared; state=PLAY; score_o=high_o=0; bcd_o=0; game_over_o=0;
//   digit_sel_o=0; digit_o=0; digit_en_o=0; scan index=0; blink counter=0, phase=on.
//  Edge detect: good_e = good_i & ~good_q and bad_e = bad_i & ~bad_q, where good_q/bad_q
//   are 1-cycle delayed copies. A level held high counts once.
//  Score and high are each held in binary and BCD. BCD increments per digit with a ripple
//   carry (9 -> 0, carry +1). Binary-to-BCD division is never used.
//  PLAY: on good_e, at the same clk edge: score += 1; if new score > high then high = new score.
//   If new score == MAX_SCORE, state -> OVER on that edge.
//   On bad_e, state -> OVER and score is unchanged. bad_e has priority over a coincident
//   good_e, which is then ignored.
//  OVER: score holds its value. On good_e, state -> PLAY and score is cleared to 0 (not
//   incremented) on that edge. bad_e is ignored.
//  clear_hi_i high: high <= 0 in both binary and BCD, in any state. It takes priority over
//   a coincident high update.
//  Displayed value: bcd_o = score BCD in PLAY and high BCD in OVER, registered. It follows
//   the state/score registers combinationally from their current values.
//  Scan: the index cycles 0,1,..,DIGITS-1,0 once per clk. Registered outputs lag the
//   index by 1 cycle:
//   - digit_sel_o = 1<<idx
//   - digit_o = bcd_o digit[idx]
//   - digit_en_o = !lz(idx) & phase
//   lz(idx) = idx>0 and all displayed digits idx..DIGITS-1 are zero. Digit 0 is never
//   blanked, so 0 shows as a single "0".
//  Blink: active only in OVER. The counter counts 0..BLINK_DIV-1; on wrap, phase toggles.
//   Entering OVER forces counter=0 and phase=on. In PLAY, phase stays on.
//  Reset mid-game: asynchronous; all state and outputs return to the reset values at once.
//  Width: score never exceeds MAX_SCORE, so there is no binary or BCD overflow. The high
//   score is bounded by MAX_SCORE.
// TESTING
//  1 reset; pulse good_i 12 times (1 cycle high, 1 low) -> score_o=12, bcd_o=0x012,
//    high_o=12; scan shows digit2 blanked, digit1=1, digit0=2.
//  2 hold good_i high for 10 cycles -> score_o increments by exactly 1.
//  3 score=7, raise good_i and bad_i on the same cycle -> score_o=7, game_over_o=1,
//    bcd_o=high (0x007 if high=7), digit_en_o toggles every BLINK_DIV cycles.
//  4 MAX_SCORE=140, drive 140 good pulses -> on the 140th edge game_over_o=1, score_o=140,
//    high_o=140, bcd_o=0x140; next good pulse -> PLAY, score_o=0, high_o=140.
//  5 in OVER with high=25, assert clear_hi_i -> high_o=0, bcd_o=0x000, only digit0 lit
//    (blinking); BCD carry check: score 99 + good -> bcd 0x100.
//  6 assert rst mid-blink with score=40 -> outputs zero in the same cycle (async);
//    after release, digit_sel_o sequence 001,010,100,001 starting 1 cycle later.

Source files
------------

// File: rtl/score_bcd_scanner.sv
// Snake-game score keeper: BCD score/high tracking, PLAY/OVER state machine and a
// time-multiplexed seven-segment scan with leading-zero blanking and game-over blink.
module score_bcd_scanner #(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned MAX_SCORE = 140,
  parameter int unsigned BLINK_DIV = 50,
  localparam int unsigned SW = $clog2(MAX_SCORE + 1),
  localparam int unsigned BW = 4 * DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              good_i,
  input  logic              bad_i,
  input  logic              clear_hi_i,
  output logic [SW-1:0]     score_o,
  output logic [SW-1:0]     high_o,
  output logic [BW-1:0]     bcd_o,
  output logic              game_over_o,
  output logic [DIGITS-1:0] digit_sel_o,
  output logic [3:0]        digit_o,
  output logic              digit_en_o
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              good_q, bad_q, good_e, bad_e;
  logic [SW-1:0]     score_nxt, high_nxt, score_inc;
  logic [BW-1:0]     score_bcd, score_bcd_nxt, score_bcd_inc;
  logic [BW-1:0]     high_bcd, high_bcd_nxt, disp_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [CW-1:0]     blink_cnt, blink_cnt_nxt;
  logic              phase, phase_nxt;
  logic [DIGITS-1:0] sel_nxt;
  logic [3:0]        digit_nxt;
  logic              en_nxt, lz;

  assign good_e = good_i & ~good_q;
  assign bad_e  = bad_i & ~bad_q;

  // Ripple-carry increment of a packed BCD value, one decimal digit per nibble.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Game state, score and high score next-state logic.
  always_comb begin
    state_nxt     = state;
    score_nxt     = score_o;
    score_bcd_nxt = score_bcd;
    high_nxt      = high_o;
    high_bcd_nxt  = high_bcd;
    score_inc     = score_o + SW'(1);
    score_bcd_inc = bcd_inc(score_bcd);
    case (state)
      PLAY: begin
        if (bad_e) begin
          state_nxt = OVER;
        end else if (good_e) begin
          score_nxt     = score_inc;
          score_bcd_nxt = score_bcd_inc;
          if (score_inc > high_o) begin
            high_nxt     = score_inc;
            high_bcd_nxt = score_bcd_inc;
          end
          if (score_inc == SW'(MAX_SCORE)) state_nxt = OVER;
        end
      end
      OVER: begin
        if (good_e) begin
          state_nxt     = PLAY;
          score_nxt     = '0;
          score_bcd_nxt = '0;
        end
      end
      default: state_nxt = PLAY;
    endcase
    if (clear_hi_i) begin
      high_nxt     = '0;
      high_bcd_nxt = '0;
    end
  end

  // Blink timer runs only while staying in OVER; any other transition restarts it lit.
  always_comb begin
    blink_cnt_nxt = '0;
    phase_nxt     = 1'b1;
    if (state == OVER && state_nxt == OVER) begin
      if (blink_cnt == CW'(BLINK_DIV - 1)) begin
        phase_nxt = ~phase;
      end else begin
        blink_cnt_nxt = blink_cnt + CW'(1);
        phase_nxt     = phase;
      end
    end
  end

  // Scan position, digit select and leading-zero blanking from the registered display.
  always_comb begin
    disp_nxt  = (state == OVER) ? high_bcd : score_bcd;
    idx_nxt   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    sel_nxt   = DIGITS'(1) << idx;
    digit_nxt = 4'd0;
    lz        = (idx != '0);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IW'(i) == idx) digit_nxt = bcd_o[4*i +: 4];
      if (i >= int'(idx) && bcd_o[4*i +: 4] != 4'd0) lz = 1'b0;
    end
    en_nxt = ~lz & phase;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PLAY;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      score_o     <= '0;
      score_bcd   <= '0;
      high_o      <= '0;
      high_bcd    <= '0;
      bcd_o       <= '0;
      game_over_o <= 1'b0;
      idx         <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b1;
      digit_sel_o <= '0;
      digit_o     <= 4'd0;
      digit_en_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_q      <= good_i;
      bad_q       <= bad_i;
      score_o     <= score_nxt;
      score_bcd   <= score_bcd_nxt;
      high_o      <= high_nxt;
      high_bcd    <= high_bcd_nxt;
      bcd_o       <= disp_nxt;
      game_over_o <= (state_nxt == OVER);
      idx         <= idx_nxt;
      blink_cnt   <= blink_cnt_nxt;
      phase       <= phase_nxt;
      digit_sel_o <= sel_nxt;
      digit_o     <= digit_nxt;
      digit_en_o  <= en_nxt;
    end
  end

endmodule

// File: tb/tb_score_bcd_scanner.sv
// Bench for score_bcd_scanner: directed game scenarios plus random play, every
// output compared each cycle against a decimal-arithmetic reference model.
module tb_score_bcd_scanner;
  localparam int DIGITS    = 3;
  localparam int MAX_SCORE = 140;
  localparam int BLINK_DIV = 50;
  localparam int SW        = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic good = 1'b0, bad = 1'b0, clr = 1'b0;
  logic [SW-1:0]     score, high;
  logic [4*DIGITS-1:0] bcd;
  logic              go, en;
  logic [DIGITS-1:0] sel;
  logic [3:0]        dig;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integers for game state and the expected scan outputs.
  int m_over, m_score, m_high, m_gq, m_bq, m_t, m_disp, m_idx;
  int e_sel, e_dig, e_en;

  score_bcd_scanner #(.DIGITS(DIGITS), .MAX_SCORE(MAX_SCORE), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .good_i(good), .bad_i(bad), .clear_hi_i(clr),
    .score_o(score), .high_o(high), .bcd_o(bcd), .game_over_o(go),
    .digit_sel_o(sel), .digit_o(dig), .digit_en_o(en)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("score", 32'(score), 32'(m_score));
    check("high", 32'(high), 32'(m_high));
    check("bcd", 32'(bcd), to_bcd(m_disp));
    check("game_over", 32'(go), 32'(m_over));
    check("digit_sel", 32'(sel), 32'(e_sel));
    check("digit", 32'(dig), 32'(e_dig));
    check("digit_en", 32'(en), 32'(e_en));
  endtask

  task automatic model_reset();
    m_over = 0; m_score = 0; m_high = 0; m_gq = 0; m_bq = 0; m_t = 0;
    m_disp = 0; m_idx = 0; e_sel = 0; e_dig = 0; e_en = 0;
  endtask

  task automatic model_edge(input int g, input int b, input int c);
    int o_over, o_score, o_high, o_disp, o_idx, o_phase, ge, be;
    o_over = m_over; o_score = m_score; o_high = m_high;
    o_disp = m_disp; o_idx = m_idx;
    o_phase = m_over ? (((m_t / BLINK_DIV) % 2) == 0) : 1;
    ge = (g != 0) && (m_gq == 0);
    be = (b != 0) && (m_bq == 0);
    if (m_over == 0) begin
      if (be != 0) m_over = 1;
      else if (ge != 0) begin
        m_score++;
        if (m_score > o_high) m_high = m_score;
        if (m_score == MAX_SCORE) m_over = 1;
      end
    end else if (ge != 0) begin
      m_over = 0;
      m_score = 0;
    end
    if (c != 0) m_high = 0;
    m_t = (o_over != 0 && m_over != 0) ? m_t + 1 : 0;
    m_disp = o_over ? o_high : o_score;
    e_sel = 1 << o_idx;
    e_dig = (o_disp / pow10(o_idx)) % 10;
    e_en = ((o_idx > 0 && o_disp < pow10(o_idx)) ? 0 : 1) & o_phase;
    m_idx = (o_idx + 1) % DIGITS;
    m_gq = g; m_bq = b;
  endtask

  task automatic step(input logic g, input logic b, input logic c);
    good = g; bad = b; clr = c;
    @(posedge clk);
    model_edge(int'(g), int'(b), int'(c));
    #1 check_all();
  endtask

  task automatic pulse();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear immediately.
  task automatic do_reset();
    good = 1'b0; bad = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    repeat (12) pulse();
    check("t1_score", 32'(score), 32'd12);
    check("t1_bcd", 32'(bcd), 32'h012);
    check("t1_high", 32'(high), 32'd12);
    idle(3);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t2_held", 32'(score), 32'd13);

    do_reset();
    repeat (7) pulse();
    step(1'b1, 1'b1, 1'b0);
    check("t3_score", 32'(score), 32'd7);
    check("t3_over", 32'(go), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("t3_bcd", 32'(bcd), 32'h007);
    idle(3 * BLINK_DIV + 5);

    do_reset();
    repeat (MAX_SCORE - 1) pulse();
    step(1'b1, 1'b0, 1'b0);
    check("t4_over", 32'(go), 32'd1);
    check("t4_score", 32'(score), 32'd140);
    check("t4_high", 32'(high), 32'd140);
    step(1'b0, 1'b0, 1'b0);
    check("t4_bcd", 32'(bcd), 32'h140);
    pulse();
    check("t4_restart", 32'(score), 32'd0);
    check("t4_keep_high", 32'(high), 32'd140);

    do_reset();
    repeat (25) pulse();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t5_high25", 32'(high), 32'd25);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    check("t5_cleared", 32'(high), 32'd0);
    check("t5_bcd0", 32'(bcd), 32'h000);
    idle(2 * BLINK_DIV + 7);
    pulse();
    repeat (99) pulse();
    check("t5_bcd99", 32'(bcd), 32'h099);
    pulse();
    check("t5_carry", 32'(bcd), 32'h100);

    for (int i = 0; i < 3000; i++)
      step(($urandom % 3) == 0, ($urandom % 40) == 0, ($urandom % 97) == 0);

    do_reset();
    repeat (40) pulse();
    step(1'b0, 1'b1, 1'b0);
    idle(BLINK_DIV + 17);
    check("t6_pre_score", 32'(score), 32'd40);
    do_reset();
    check("t6_async_score", 32'(score), 32'd0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
